// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request FSM over a word RAM with
// configurable read latency. Define DMEM_BYTE_LANE_EN to honour i_be on writes.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);
    localparam int unsigned IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic          err;
        logic [IW-1:0] idx;
    } req_t;

    state_t          state, nstate;
    req_t            req;
    logic [32:0]     off;
    logic            accept;
    logic            rdy_en;
    logic [3:0]      cnt;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [3:0]      be_eff;
    logic [3:0]      wmask;
    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Borrow out of the 33-bit subtract lands above LIMIT, so one compare covers both bounds.
    assign off     = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    assign req.we  = i_we;
    assign req.err = (i_addr[1:0] != 2'b00) || (off >= LIMIT);
    assign req.idx = off[IW+1:2];
    assign accept  = i_req & o_ready;

`ifdef DMEM_BYTE_LANE_EN
    assign be_eff = i_be;
`else
    logic be_unused;
    assign be_eff    = 4'hF;
    assign be_unused = ^i_be;
`endif

    assign wmask = {4{accept & req.we & ~req.err}} & be_eff;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[req.idx][b] <= i_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (accept) begin
                if (req.err || req.we || READ_LATENCY == 1) nstate = RESP;
                else                                        nstate = BUSY;
            end
            BUSY:    if (cnt == 4'd1) nstate = RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE) && rdy_en;
        o_valid = (state == RESP);
        o_err   = (state == RESP) && err_q;
    end

    // rdy_en holds o_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en  <= 1'b0;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                err_q   <= req.err;
                rdata_q <= (!req.we && !req.err) ? mem[req.idx] : 32'h0;
                if (!req.we && !req.err) cnt <= CNT_LOAD;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign o_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a word-array model.
module tb_dmem_responder;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_we;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_be;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] mm [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_be(i_be), .o_ready(o_ready), .o_valid(o_valid),
        .o_rdata(o_rdata), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One transaction: model predicts error, data and latency from the address rules.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit hold, output int acc);
        longint      a;
        bit          err_e;
        int          idx, lat_e, k, n;
        logic [31:0] rd_e;
        logic [3:0]  be_on;
        a      = longint'(addr);
        err_e  = (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
        idx    = err_e ? 0 : int'((a - longint'(BASE)) / 4);
        lat_e  = (err_e || we) ? 1 : LAT;
        rd_e   = (err_e || we) ? 32'h0 : mm[idx];
`ifdef DMEM_BYTE_LANE_EN
        be_on  = be;
`else
        be_on  = 4'hF;
`endif
        if (we && !err_e)
            for (int b = 0; b < 4; b++)
                if (be_on[b]) mm[idx][8*b +: 8] = wdata[8*b +: 8];

        n = 0;
        @(negedge clk);
        while (o_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("ready_wait", o_ready, 1'b1);
        acc     = cyc;
        i_req   = 1'b1;
        i_we    = we;
        i_addr  = addr;
        i_wdata = wdata;
        i_be    = be;
        @(posedge clk);
        #1;
        if (!hold) i_req = 1'b0;
        k = 1;
        while (o_valid !== 1'b1 && k < 20) begin
            check1("ready_busy", o_ready, 1'b0);
            @(posedge clk);
            #1;
            k++;
        end
        check1("ready_resp", o_ready, 1'b0);
        check("latency", 32'(k), 32'(lat_e));
        check("rdata", o_rdata, rd_e);
        check1("err", o_err, err_e);
        @(posedge clk);
        #1;
        check1("valid_drop", o_valid, 1'b0);
        check1("err_drop", o_err, 1'b0);
        check("rdata_hold", o_rdata, rd_e);
        check1("ready_idle", o_ready, 1'b1);
    endtask

    initial begin
        int          acc0, acc1, acc2, dummy;
        logic [31:0] addr, exp_lane;
        reset = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;

        repeat (3) @(posedge clk);
        #1;
        check1("rst_ready", o_ready, 1'b0);
        check1("rst_valid", o_valid, 1'b0);
        check1("rst_err", o_err, 1'b0);
        check("rst_rdata", o_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check1("rel_ready_low", o_ready, 1'b0);
        @(posedge clk);
        #1;
        check1("rel_ready", o_ready, 1'b1);
        check1("rel_valid", o_valid, 1'b0);
        check("rel_rdata", o_rdata, 32'h0);
        check1("rel_err", o_err, 1'b0);

        for (int i = 0; i < DEPTH; i++) txn(1'b1, BASE + 32'(i * 4), $urandom, 4'hF, 1'b0, dummy);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, dummy);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, dummy);
        check("deadbeef_model", mm[4], 32'hDEAD_BEEF);

        txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, dummy);
        txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, dummy);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, dummy);
`ifdef DMEM_BYTE_LANE_EN
        exp_lane = 32'h11BB_33DD;
`else
        exp_lane = 32'hAABB_CCDD;
`endif
        check("lane_result", o_rdata, exp_lane);
        txn(1'b1, 32'h20, 32'h5555_5555, 4'b0000, 1'b0, dummy);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, dummy);

        txn(1'b0, 32'h0000_0402, 32'h0, 4'h0, 1'b0, dummy);
        txn(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 1'b0, dummy);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, dummy);
        txn(1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 4'hF, 1'b0, dummy);
        txn(1'b0, 32'h0000_03FC, 32'h0, 4'h0, 1'b0, dummy);

        txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc0);
        txn(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, acc1);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, acc2);
        check("b2b_space1", 32'(acc1 - acc0), 32'(LAT + 1));
        check("b2b_space2", 32'(acc2 - acc1), 32'(LAT + 1));

        // Reset while a read is in flight: no response, RAM kept.
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h10;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        check1("mid_busy_ready", o_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check1("mid_rst_valid", o_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("mid_rst_hold_valid", o_valid, 1'b0);
            check1("mid_rst_hold_ready", o_ready, 1'b0);
        end
        reset = 1'b1;
        #1;
        check1("mid_rel_ready_low", o_ready, 1'b0);
        @(posedge clk);
        #1;
        check1("mid_rel_ready", o_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("mid_no_valid", o_valid, 1'b0);
        end
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, dummy);

        for (int i = 0; i < 80; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'($urandom_range(0, 259) * 4 + $urandom_range(1, 3));
            else             addr = 32'($urandom_range(0, 257) * 4);
            txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b0, dummy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory interface. The core issues a request carrying address, write data and write enable; this block services it from a word-organised RAM and returns read data with a valid/ready handshake.
- Supports a configurable read latency, so the datapath can later move to a multi-cycle or stalled memory model.
- Sits between the datapath's ALUResult/WriteData/ReadData signals and the on-chip data RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- READ_LATENCY, 2, cycles from the accept edge to o_valid for reads; legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  request strobe from the core.
- i_we  input  1  1 = write, 0 = read; sampled at accept.
- i_addr  input  32  byte address; sampled at accept.
- i_wdata  input  32  write data; sampled at accept.
- i_be  input  4  byte enables; bit n covers byte n, i.e. [8n+7:8n].
- o_ready  output  1  block can accept a request this cycle.
- o_valid  output  1  one-cycle response strobe.
- o_rdata  output  32  read data; meaningful only while o_valid is high.
- o_err  output  1  error flag; meaningful only while o_valid is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; the latency counter clears.
  - o_ready=0, o_valid=0, o_err=0, o_rdata=32'h0.
  - RAM contents are not cleared.
  - A pending transaction is dropped with no response. A write that has not been accepted is never committed.
  - o_ready rises on the first clk edge after reset deasserts.
- States: IDLE, BUSY, RESP.
- IDLE:
  - o_ready=1.
  - Accept happens on a rising edge where i_req=1 and o_ready=1. At that edge i_we, i_addr, i_wdata and i_be are latched.
- Address check at accept:
  - Error when i_addr[1:0] != 0, i_addr < BASE_ADDR, or i_addr >= BASE_ADDR + 4*DEPTH_WORDS.
  - Word index = (i_addr - BASE_ADDR) >> 2.
- Write, no error:
  - The enabled bytes of RAM[index] update on the accept edge.
  - Next state is RESP: o_valid=1 one cycle after accept, with o_rdata=0 and o_err=0.
- Read, no error:
  - RAM[index] is captured into the response register at the accept edge.
  - If READ_LATENCY=1, next state is RESP.
  - Otherwise next state is BUSY, the counter loads READ_LATENCY-1 and decrements each cycle. The FSM moves to RESP when the counter reaches 1.
  - o_valid is high exactly READ_LATENCY cycles after the accept edge.
- Error (read or write):
  - RAM is untouched; next state is RESP.
  - o_valid=1, o_err=1, o_rdata=0 one cycle after accept, regardless of READ_LATENCY.
- BUSY and RESP:
  - o_ready=0; i_req is ignored (no queuing).
  - A request held high across RESP is accepted on the first IDLE edge.
- RESP:
  - o_valid=1 for exactly one cycle, then the FSM returns to IDLE.
  - o_rdata holds its value after o_valid drops, until the next response.
  - o_err returns to 0 when o_valid drops.
- Only one transaction is outstanding at a time.
- Read-after-write to the same address returns the new data, because the write commits before the next accept.
- Counter width is 4 bits, which covers READ_LATENCY up to 8 without wrap.

Optional Feature:
- Macro: DMEM_BYTE_LANE_EN.
- Defined: i_be controls which bytes are written. A write with i_be=4'b0000 changes no bytes but still responds with o_valid=1, o_err=0.
- Undefined: i_be is ignored and every non-error write updates all 32 bits. Reads are unaffected in both builds.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release → o_ready=1 on the next edge; o_valid=0, o_rdata=0, o_err=0.
- Write then read (READ_LATENCY=2):
  - Write 32'hDEAD_BEEF to 0x10 with i_be=4'hF → o_valid exactly one cycle after accept, o_err=0.
  - Read 0x10 → o_valid exactly 2 cycles after accept, o_rdata=32'hDEAD_BEEF.
- Byte lanes (macro defined):
  - Preload 0x20 with 32'h1122_3344, write 32'hAABB_CCDD with i_be=4'b0101, read back → 32'h11BB_33DD.
  - Same sequence with the macro undefined → 32'hAABB_CCDD.
- Errors:
  - Read 0x0000_0402 → o_valid one cycle after accept, o_err=1, o_rdata=0.
  - Write to 0x0000_0400 (DEPTH_WORDS=256, BASE_ADDR=0) → o_err=1, and a subsequent read of 0x0 is unchanged.
- Back-to-back: hold i_req=1 with reads to 0x0, 0x4, 0x8 → accepts are spaced READ_LATENCY+1 cycles apart; o_ready=0 during BUSY and RESP; responses arrive in order with the correct data.
- Reset mid-read: accept a read, assert reset=0 during BUSY → o_valid never pulses; after release, state is IDLE with o_ready=1 and RAM intact.
